piso_tx_scheduler: RTL and testbench

PISO_TX_SCHEDULER -- requirements
Module: piso_tx_scheduler

---
 rtl/piso_tx_scheduler_if.sv | 21 ++
 rtl/piso_tx_scheduler.sv | 125 ++++++++++++
 tb/tb_piso_tx_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/piso_tx_scheduler_if.sv
// Requester handshake bundle for piso_tx_scheduler.
// One instance per requester: valid/data in, ready back.
interface piso_tx_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Round-robin word scheduler feeding a PISO shift register.
// Grants one of two requesters, loads the word, paces the shifts.
module piso_tx_scheduler #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  piso_tx_scheduler_if.slave req0,
  piso_tx_scheduler_if.slave req1,
  input  logic [DIV_W-1:0]  bit_div,
  output logic              piso_load,
  output logic [DATA_W-1:0] piso_data,
  output logic              piso_shift,
  output logic              busy,
  output logic              grant_id,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              rr_ptr;
  logic [DIV_W-1:0]  period;
  logic [DIV_W-1:0]  cnt;
  logic [CW-1:0]     bits;
  logic              win0;
  logic              win1;
  logic              hs;
  logic              tick;
  logic              last;

  // Arbitration: one ready at most, only in IDLE and out of reset.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (rst && state == IDLE) begin
      win0 = req0.valid && (!req1.valid || !rr_ptr);
      win1 = req1.valid && (!req0.valid || rr_ptr);
    end
  end

  assign req0.ready = win0;
  assign req1.ready = win1;
  assign hs         = win0 | win1;

  assign tick = (state == SHIFT) && (cnt == period);
  assign last = (bits == LAST);

  assign piso_load  = (state == LOAD);
  assign piso_shift = tick;
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (hs) state_nx = LOAD;
      LOAD:  state_nx = SHIFT;
      SHIFT: if (tick && last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word capture, bit pacing and round-robin update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= 1'b0;
      grant_id  <= 1'b0;
      piso_data <= '0;
      period    <= '0;
      cnt       <= '0;
      bits      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            piso_data <= win1 ? req1.data : req0.data;
            period    <= bit_div;
            grant_id  <= win1;
          end
        end
        LOAD: begin
          cnt  <= '0;
          bits <= '0;
        end
        SHIFT: begin
          if (tick) begin
            cnt  <= '0;
            bits <= bits + CW'(1);
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DONE: begin
          rr_ptr <= ~grant_id;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: random words vs. a cycle-count model.
// Model predicts every cycle from grant rules and period arithmetic.
module tb_piso_tx_scheduler;

  localparam int DW = 8;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [VW-1:0] bit_div = '0;
  logic          piso_load;
  logic [DW-1:0] piso_data;
  logic          piso_shift;
  logic          busy;
  logic          grant_id;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int m_rr     = 0;

  piso_tx_scheduler_if #(.DATA_W(DW)) req0_if ();
  piso_tx_scheduler_if #(.DATA_W(DW)) req1_if ();

  piso_tx_scheduler #(
    .DATA_W(DW),
    .DIV_W (VW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0_if.slave),
    .req1      (req1_if.slave),
    .bit_div   (bit_div),
    .piso_load (piso_load),
    .piso_data (piso_data),
    .piso_shift(piso_shift),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs_vec();
    return {req0_if.ready, req1_if.ready,
            piso_load, piso_shift, done, busy};
  endfunction

  // Present one request set at a negedge in IDLE and follow the word.
  task automatic run_word(input bit v0, input bit v1,
                          input logic [7:0] d0,
                          input logic [7:0] d1,
                          input int p, input int mid_div);
    int win;
    int n;
    int shifts;
    logic [7:0] wd;
    logic [5:0] e;
    req0_if.valid = v0;
    req1_if.valid = v1;
    req0_if.data  = d0;
    req1_if.data  = d1;
    bit_div       = VW'(p);
    #1;
    if (!v0 && !v1) begin
      chk("idle_quiet", obs_vec(), 6'b0);
      @(negedge clk);
      return;
    end
    win = (v0 && v1) ? m_rr : (v1 ? 1 : 0);
    wd  = (win == 1) ? d1 : d0;
    chk("ready", {req0_if.ready, req1_if.ready},
        (win == 1) ? 2'b01 : 2'b10);
    n = 2 + DW * (p + 1);
    shifts = 0;
    @(posedge clk);
    for (int k = 1; k <= n + 1; k++) begin
      #1;
      req0_if.data = 8'($urandom);
      req1_if.data = 8'($urandom);
      bit_div      = VW'(mid_div);
      @(negedge clk);
      if (k <= n) begin
        e = {2'b00, k == 1,
             (k >= 2 && k <= n - 1 &&
              ((k - 2) % (p + 1)) == p),
             k == n, 1'b1};
        chk($sformatf("cyc%0d_p%0d", k, p), obs_vec(), e);
        if (piso_shift) shifts++;
        if (k == 1) begin
          chk("grant_id", grant_id, win);
          chk("load_data", piso_data, wd);
        end
      end else begin
        chk("back_idle", obs_vec() & 6'b001111, 6'b0);
        chk("hold_data", piso_data, wd);
        chk("shift_cnt", shifts, DW);
      end
    end
    m_rr = 1 - win;
  endtask

  initial begin
    int seen;
    bit hit;
    req0_if.valid = 1'b1;
    req1_if.valid = 1'b1;
    req0_if.data  = 8'h3C;
    req1_if.data  = 8'hC3;
    repeat (3) @(negedge clk);
    chk("rst_outs", obs_vec(), 6'b0);
    chk("rst_data", piso_data, 8'h00);
    chk("rst_grant", grant_id, 1'b0);
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    rst  = 1'b1;
    m_rr = 0;
    @(negedge clk);

    run_word(0, 1, 8'h00, 8'h77, 1, 1);
    for (int i = 0; i < 4; i++)
      run_word(1, 1, 8'h11, 8'h22, i % 3, 200);
    run_word(1, 0, 8'hA5, 8'h00, 0, 0);
    run_word(1, 0, 8'h96, 8'h00, 3, 3);
    run_word(1, 1, 8'h5E, 8'hE5, 1, 7);
    run_word(1, 1, 8'h6D, 8'hD6, 7, 1);

    for (int i = 0; i < 24; i++)
      run_word(1'($urandom), 1'($urandom),
               8'($urandom), 8'($urandom),
               $urandom_range(0, 3),
               $urandom_range(0, 255));

    req1_if.valid = 1'b1;
    req1_if.data  = 8'h5A;
    req0_if.valid = 1'b0;
    bit_div       = 8'd1;
    @(posedge clk);
    seen = 0;
    hit  = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (piso_shift) seen++;
      if (seen == 4) hit = 1'b1;
    end
    chk("reach_4th", hit, 1'b1);
    req0_if.valid = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("async_outs", obs_vec(), 6'b0);
    chk("async_data", piso_data, 8'h00);
    chk("async_grant", grant_id, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_hold", obs_vec(), 6'b0);
    end
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    rst  = 1'b1;
    m_rr = 0;
    @(negedge clk);
    run_word(1, 0, 8'hC7, 8'h00, 2, 5);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
